// File: rtl/sad_datapath.sv
// sad_datapath: SAD datapath with operand memories, index counter, operand registers, accumulator and result capture
module sad_datapath #(
  parameter int DATA_W = 8,
  parameter int N      = 32,
  parameter int ADDR_W = 5,
  parameter int SUM_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_clr,
  input  logic              i_ld,
  input  logic              temp1_clr,
  input  logic              temp1_ld,
  input  logic              temp2_clr,
  input  logic              temp2_ld,
  input  logic              sum_clr,
  input  logic              sum_ld,
  input  logic              muxsel,
  input  logic              R_en,
  input  logic              done,
  input  logic              mem_we,
  input  logic              mem_sel,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              temp1_gt_temp2,
  output logic              i_lt_32,
  output logic [SUM_W-1:0]  sad_out,
  output logic              sad_valid
);
  localparam logic [ADDR_W:0] N_I = (ADDR_W+1)'(N);
  logic [DATA_W-1:0] mem_a [2**ADDR_W];
  logic [DATA_W-1:0] mem_b [2**ADDR_W];
  logic [ADDR_W:0]   i;
  logic [DATA_W-1:0] rd_a, rd_b, temp1, temp2, diff;
  logic [SUM_W-1:0]  sum;
  assign temp1_gt_temp2 = temp1 > temp2;
  assign i_lt_32        = i < N_I;
  assign diff           = muxsel ? temp1 - temp2 : temp2 - temp1;
  // Memories are deliberately outside reset so preloaded data survives an abort
  always_ff @(posedge Clk) begin
    if (mem_we && !mem_sel) mem_a[mem_waddr] <= mem_wdata;
    if (mem_we && mem_sel) mem_b[mem_waddr] <= mem_wdata;
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      i         <= '0;
      rd_a      <= '0;
      rd_b      <= '0;
      temp1     <= '0;
      temp2     <= '0;
      sum       <= '0;
      sad_out   <= '0;
      sad_valid <= 1'b0;
    end else begin
      i     <= i_clr ? '0 : (i_ld && i < N_I) ? i + 1'b1 : i;
      rd_a  <= R_en ? mem_a[i[ADDR_W-1:0]] : rd_a;
      rd_b  <= R_en ? mem_b[i[ADDR_W-1:0]] : rd_b;
      temp1 <= temp1_clr ? '0 : temp1_ld ? rd_a : temp1;
      temp2 <= temp2_clr ? '0 : temp2_ld ? rd_b : temp2;
      sum   <= sum_clr ? '0 : sum_ld ? sum + SUM_W'(diff) : sum;
      // Capture samples the pre-edge sum and overrides a coincident clear of the valid flag
      sad_out   <= done ? sum : sad_out;
      sad_valid <= done ? 1'b1 : sum_clr ? 1'b0 : sad_valid;
    end
  end
endmodule
